// File: rtl/tpu_out_requant_writer_if.sv
// tpu_out_requant_writer_if: row stream in, BRAM write port out
// slave  : requant writer side (consumes rows, drives the BRAM write port)
// master : environment side (produces rows, owns mem_grant, observes writes)
interface tpu_out_requant_writer_if #(
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int AWIDTH      = 10
);
  logic                          in_valid;
  logic [DESIGN_SIZE*ACC_WIDTH-1:0] in_data;
  logic                          in_ready;
  logic                          mem_grant;
  logic [AWIDTH-1:0]             bram_addr;
  logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata;
  logic [DESIGN_SIZE-1:0]        bram_we;
  modport slave (
    input  in_valid, in_data, mem_grant,
    output in_ready, bram_addr, bram_wdata, bram_we
  );
  modport master (
    output in_valid, in_data, mem_grant,
    input  in_ready, bram_addr, bram_wdata, bram_we
  );
endinterface

// File: rtl/tpu_out_requant_writer.sv
// tpu_out_requant_writer: round/saturate accumulator rows to Q5.3 and write them to BRAM
// clk, reset       : clock, synchronous active-high reset
// start_i, cfg_*_i : job launch pulse and job configuration (latched on launch)
// bus              : row stream in, BRAM write port out
// busy_o, done_o   : job active, one-cycle end-of-job pulse
// sat_count_o      : enabled lanes clipped during the current job
module tpu_out_requant_writer #(
  parameter int DESIGN_SIZE       = 16,
  parameter int DWIDTH            = 8,
  parameter int ACC_WIDTH         = 20,
  parameter int AWIDTH            = 10,
  parameter int ADDR_STRIDE_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [AWIDTH-1:0]            cfg_base_addr_i,
  input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_i,
  input  logic [AWIDTH-1:0]            cfg_num_rows_i,
  input  logic [DESIGN_SIZE-1:0]       cfg_lane_mask_i,
  tpu_out_requant_writer_if.slave      bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  sat_count_o
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int PW = $clog2(DESIGN_SIZE + 1);
  localparam int RW = DESIGN_SIZE * DWIDTH;
  localparam logic signed [ACC_WIDTH:0] RND  = 4;
  localparam logic signed [ACC_WIDTH:0] MAXV = 2 ** (DWIDTH - 1) - 1;
  localparam logic signed [ACC_WIDTH:0] MINV = -(2 ** (DWIDTH - 1));
  state_t state_q, state_d;
  logic [AWIDTH-1:0] num_q, num_d, acc_q, acc_d, wr_q, wr_d, addr_q, addr_d, s2_addr_q, s2_addr_d;
  logic [ADDR_STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [DESIGN_SIZE-1:0] mask_q, mask_d, sat_lane;
  logic [15:0] sat_q, sat_d;
  logic [16:0] sat_sum;
  logic [PW-1:0] pop;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [RW-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, rq;
  logic commit, s2_adv, s1_adv, accept, launch;
  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    logic signed [ACC_WIDTH:0] r;
    // one extra bit so the rounding add cannot overflow; >>> floors, giving round-half-up
    assign r = ($signed({bus.in_data[(i+1)*ACC_WIDTH-1], bus.in_data[i*ACC_WIDTH +: ACC_WIDTH]}) + RND) >>> 3;
    assign sat_lane[i] = (r > MAXV) || (r < MINV);
    assign rq[i*DWIDTH +: DWIDTH] = r > MAXV ? {1'b0, {(DWIDTH-1){1'b1}}} :
                                    r < MINV ? {1'b1, {(DWIDTH-1){1'b0}}} : r[DWIDTH-1:0];
  end
  always_comb begin
    pop = '0;
    for (int k = 0; k < DESIGN_SIZE; k++) pop = pop + PW'(sat_lane[k] & mask_q[k]);
  end
  always_comb begin
    commit = s2_v_q && bus.mem_grant;
    s2_adv = !s2_v_q || commit;
    s1_adv = !s1_v_q || s2_adv;
    bus.in_ready = (state_q == RUN) && (acc_q < num_q) && s1_adv;
    accept = bus.in_valid && bus.in_ready;
    bus.bram_we = commit ? mask_q : '0;
    bus.bram_addr = s2_addr_q;
    bus.bram_wdata = s2_data_q;
    launch = (state_q == IDLE) && start_i;
    num_d = launch ? cfg_num_rows_i : num_q;
    stride_d = launch ? cfg_stride_i : stride_q;
    mask_d = launch ? cfg_lane_mask_i : mask_q;
    acc_d = launch ? '0 : acc_q + AWIDTH'(accept);
    wr_d = launch ? '0 : wr_q + AWIDTH'(commit);
    addr_d = launch ? cfg_base_addr_i : commit ? addr_q + stride_q[AWIDTH-1:0] : addr_q;
    sat_sum = {1'b0, sat_q} + 17'(pop);
    sat_d = launch ? '0 : accept ? (sat_sum[16] ? 16'hFFFF : sat_sum[15:0]) : sat_q;
    s1_v_d = s1_adv ? accept : s1_v_q;
    s1_data_d = accept ? rq : s1_data_q;
    s2_v_d = s2_adv ? s1_v_q : s2_v_q;
    s2_data_d = (s2_adv && s1_v_q) ? s1_data_q : s2_data_q;
    // the row entering s2 is the next one to be written, so it takes next_addr after this cycle's commit
    s2_addr_d = (s2_adv && s1_v_q) ? addr_d : s2_addr_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? (cfg_num_rows_i == '0 ? DONE : RUN) : IDLE;
      RUN:     state_d = acc_d == num_q ? FLUSH : RUN;
      FLUSH:   state_d = wr_d == num_q ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      num_q     <= '0;
      stride_q  <= '0;
      mask_q    <= '0;
      acc_q     <= '0;
      wr_q      <= '0;
      addr_q    <= '0;
      sat_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      stride_q  <= stride_d;
      mask_q    <= mask_d;
      acc_q     <= acc_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      sat_q     <= sat_d;
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_addr_q <= s2_addr_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign sat_count_o = sat_q;
endmodule

// File: tb/tb_tpu_out_requant_writer.sv
// tb_tpu_out_requant_writer: vector table, directed sequences and random jobs against a reference model
module tb_tpu_out_requant_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic start;
  logic [9:0] cfg_base, cfg_num;
  logic [15:0] cfg_stride, cfg_mask, sat_count;
  logic busy, done;
  tpu_out_requant_writer_if #(.DESIGN_SIZE(16), .DWIDTH(8), .ACC_WIDTH(20), .AWIDTH(10)) bus ();
  tpu_out_requant_writer dut (
    .clk(clk), .reset(reset), .start_i(start), .cfg_base_addr_i(cfg_base), .cfg_stride_i(cfg_stride),
    .cfg_num_rows_i(cfg_num), .cfg_lane_mask_i(cfg_mask), .bus(bus), .busy_o(busy), .done_o(done),
    .sat_count_o(sat_count)
  );
  int ntests = 0, nfail = 0;
  logic [319:0] rows [16];
  logic [127:0] last_wdata;
  int first_wcyc, last_wcyc, last_acc, done_cyc;
  typedef struct { int x; logic [7:0] b; bit s; } vec_t;
  vec_t tv [14];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: floor((x+4)/8) with plain integer arithmetic, clipped to the signed byte range
  function automatic logic [7:0] q53(input int x, output bit s);
    int v, r;
    v = x + 4;
    r = v >= 0 ? v / 8 : -((-v + 7) / 8);
    s = (r > 127) || (r < -128);
    return r > 127 ? 8'h7F : r < -128 ? 8'h80 : 8'(r);
  endfunction
  function automatic int lane(input logic [319:0] row, input int l);
    logic signed [19:0] t;
    t = row[l*20 +: 20];
    return int'(t);
  endfunction
  task automatic run_job(input string tag, input logic [9:0] base, input logic [15:0] stride,
                         input logic [9:0] n, input logic [15:0] mask, input int gpct, input int vpct,
                         input int extra, input int stall_at, input int restart_at);
    logic [9:0] ea [16];
    logic [127:0] ed [16];
    logic [9:0] hold_a;
    logic [127:0] hold_d;
    int esat, nvis, idx, wc;
    bit s, got_done, stall;
    esat = 0;
    for (int i = 0; i < int'(n); i++) begin
      ea[i] = 10'(int'(base) + i * int'(stride));
      for (int l = 0; l < 16; l++) begin
        ed[i][l*8 +: 8] = q53(lane(rows[i], l), s);
        if (s && mask[l]) esat++;
      end
    end
    if (esat > 65535) esat = 65535;
    nvis = mask == 0 ? 0 : int'(n);
    idx = 0; wc = 0; got_done = 0;
    @(negedge clk);
    cfg_base = base; cfg_stride = stride; cfg_num = n; cfg_mask = mask; start = 1'b1;
    for (int c = 0; c < 2000 && !got_done; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      cfg_base = start ? base + 10'd7 : base;
      cfg_num = start ? n + 10'd2 : n;
      stall = stall_at >= 0 && c >= stall_at && c < stall_at + 5;
      bus.mem_grant = stall ? 1'b0 : ($urandom_range(99) < gpct);
      bus.in_valid = idx < int'(n) + extra && ($urandom_range(99) < vpct);
      bus.in_data = rows[idx < 16 ? idx : 15];
      #1;
      if (stall) begin
        chk({tag, " stall_we"}, bus.bram_we, 0);
        if (c - stall_at >= 2) chk({tag, " stall_ready"}, bus.in_ready, 0);
        if (c - stall_at == 2) begin hold_a = bus.bram_addr; hold_d = bus.bram_wdata; end
        if (c - stall_at > 2) begin
          chk({tag, " stall_addr"}, bus.bram_addr, hold_a);
          chk({tag, " stall_data"}, bus.bram_wdata, hold_d);
        end
      end
      if (bus.bram_we != 0) begin
        if (wc < nvis) begin
          chk({tag, " addr"}, bus.bram_addr, ea[wc]);
          chk({tag, " data"}, bus.bram_wdata, ed[wc]);
          chk({tag, " we"}, bus.bram_we, mask);
        end else chk({tag, " extra_write"}, 1, 0);
        if (wc == 0) first_wcyc = c;
        last_wcyc = c;
        last_wdata = bus.bram_wdata;
        wc++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (idx >= int'(n)) chk({tag, " row_beyond_num"}, idx, n);
        last_acc = c;
        idx++;
      end
      if (done) begin got_done = 1; done_cyc = c; end
    end
    bus.in_valid = 1'b0;
    chk({tag, " done_seen"}, got_done, 1);
    chk({tag, " writes"}, wc, nvis);
    chk({tag, " accepted"}, idx, n);
    chk({tag, " sat_count"}, sat_count, esat);
    @(negedge clk);
    #1;
    chk({tag, " idle_after"}, {busy, done}, 0);
  endtask
  initial begin
    bit bad;
    start = 0; cfg_base = 0; cfg_num = 0; cfg_stride = 0; cfg_mask = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.mem_grant = 1;
    tv[0] = '{4352, 8'h7F, 1};  tv[1] = '{96, 8'h0C, 0};      tv[2] = '{-4, 8'h00, 0};
    tv[3] = '{-5, 8'hFF, 0};    tv[4] = '{8188, 8'h7F, 1};    tv[5] = '{-8192, 8'h80, 1};
    tv[6] = '{1019, 8'h7F, 0};  tv[7] = '{1020, 8'h7F, 1};    tv[8] = '{-1028, 8'h80, 0};
    tv[9] = '{-1029, 8'h80, 1}; tv[10] = '{3, 8'h00, 0};      tv[11] = '{4, 8'h01, 0};
    tv[12] = '{524287, 8'h7F, 1}; tv[13] = '{-524288, 8'h80, 1};
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready_we", {bus.in_ready, bus.bram_we}, 0);
    chk("reset_addr", bus.bram_addr, 0);
    chk("reset_wdata", bus.bram_wdata, 0);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_sat", sat_count, 0);
    reset = 0;
    for (int i = 0; i < 14; i++) begin
      rows[0] = {16{20'(tv[i].x)}};
      run_job($sformatf("vec%0d", i), 10'h20, 16'd1, 10'd1, 16'hFFFF, 100, 100, 0, -1, -1);
      chk($sformatf("vec%0d bytes", i), last_wdata, {16{tv[i].b}});
      chk($sformatf("vec%0d sat", i), sat_count, tv[i].s ? 16 : 0);
      chk($sformatf("vec%0d done_latency", i), done_cyc - last_acc, 3);
    end
    rows[0] = '0;
    rows[0][0 +: 20] = 20'(96); rows[0][20 +: 20] = 20'(-4); rows[0][40 +: 20] = 20'(-5);
    rows[0][60 +: 20] = 20'(8188); rows[0][80 +: 20] = 20'(-8192);
    run_job("mixed", 10'h20, 16'd1, 10'd1, 16'hFFFF, 100, 100, 0, -1, -1);
    chk("mixed bytes", last_wdata, 128'h807FFF000C);
    chk("mixed sat", sat_count, 2);
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++) rows[r][l*20 +: 20] = 20'(int'($urandom_range(0, 4095)) - 2048);
    run_job("wrap", 10'h3FE, 16'd1, 10'd4, 16'hFFFF, 100, 100, 1, -1, -1);
    chk("wrap back_to_back", last_wcyc - first_wcyc, 3);
    run_job("stall", 10'h40, 16'd3, 10'd8, 16'hFFFF, 100, 100, 0, 3, -1);
    run_job("mask", 10'h20, 16'd2, 10'd2, 16'h00FF, 100, 100, 0, -1, -1);
    run_job("zero_rows", 10'h55, 16'd1, 10'd0, 16'hFFFF, 100, 100, 1, -1, -1);
    run_job("mask_zero", 10'h10, 16'd1, 10'd3, 16'h0000, 100, 100, 0, -1, -1);
    run_job("restart", 10'h100, 16'd4, 10'd5, 16'hFFFF, 80, 100, 0, -1, 2);
    @(negedge clk);
    cfg_base = 10'h10; cfg_stride = 1; cfg_num = 2; cfg_mask = 16'hFFFF; start = 1;
    @(negedge clk);
    start = 0; bus.in_valid = 1; bus.mem_grant = 1; bus.in_data = rows[0];
    #1;
    chk("rst_mid first_accept", bus.in_ready, 1);
    @(negedge clk);
    reset = 1; bus.in_valid = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mid busy", busy, 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      bad |= (bus.bram_we != 0) || done;
    end
    chk("rst_mid no_write_done", bad, 0);
    for (int j = 0; j < 25; j++) begin
      logic [9:0] n;
      n = 10'($urandom_range(1, 12));
      for (int r = 0; r < 16; r++)
        for (int l = 0; l < 16; l++)
          rows[r][l*20 +: 20] = $urandom_range(1) ? 20'(int'($urandom_range(0, 4095)) - 2048) : 20'($urandom);
      run_job($sformatf("rand%0d", j), 10'($urandom), $urandom_range(3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 40)),
              n, 16'($urandom) | 16'h1, $urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(0, 2), -1, -1);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/tpu_out_requant_writer.md
Name: tpu_out_requant_writer

Overview:
- Sits directly downstream of the systolic array and the activation stage in the Q5.3 TPU.
- Accepts one result row per beat: DESIGN_SIZE lanes of wide accumulator values in Q(ACC_WIDTH-6).6.
- Rounds and saturates each lane to Q5.3, packs the row, and writes it into the matrix-C region of BRAM A at base + n*stride.
- Pulses done after the programmed number of rows has been committed.

Parameters:
- DESIGN_SIZE, 16, lanes per row.
- DWIDTH, 8, output element width (Q5.3).
- ACC_WIDTH, 20, signed accumulator lane width; 6 fractional bits.
- AWIDTH, 10, BRAM address width.
- ADDR_STRIDE_WIDTH, 16, stride register width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that launches a job; sampled only in IDLE.
- cfg_base_addr  in  AWIDTH  matrix C base address (REG_MATRIX_C_ADDR).
- cfg_stride  in  ADDR_STRIDE_WIDTH  row address increment.
- cfg_num_rows  in  AWIDTH  rows in the job.
- cfg_lane_mask  in  DESIGN_SIZE  valid columns (REG_VALID_MASK_B_COLS).
- in_valid  in  1  upstream row valid.
- in_data  in  DESIGN_SIZE*ACC_WIDTH  lane i = bits [i*ACC_WIDTH +: ACC_WIDTH].
- in_ready  out  1  row accepted when in_valid && in_ready.
- mem_grant  in  1  BRAM write port available this cycle (arbitration against the external port).
- bram_addr  out  AWIDTH  write address.
- bram_wdata  out  DESIGN_SIZE*DWIDTH  packed Q5.3 row.
- bram_we  out  DESIGN_SIZE  per-lane write enable.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at job end.
- sat_count  out  16  lanes clipped during the current job.

Behaviour:
- Reset values: in_ready=0, bram_we=0, bram_addr=0, bram_wdata=0, busy=0, done=0, sat_count=0, state=IDLE, both pipeline stages empty.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start. On this transition: latch all cfg_* values, set next_addr=cfg_base_addr, clear accepted/written counters, clear sat_count.
- IDLE -> DONE on start with cfg_num_rows=0. done pulses the next cycle; no write is issued.
- RUN -> FLUSH when accepted == num_rows.
- FLUSH -> DONE when written == num_rows.
- DONE -> IDLE unconditionally; done=1 only in DONE.
- start outside IDLE is ignored.
- Stage 1 (requant register), per lane x:
  - r = (x + 4) >>> 3, computed arithmetically at ACC_WIDTH+1 bits (round half up).
  - If r > 127: output 0x7F and the lane counts as saturated.
  - If r < -128: output 0x80 and the lane counts as saturated.
  - Otherwise output r[7:0].
- sat_count adds the popcount of saturated lanes that are enabled by the mask, at stage-1 load. It saturates at 0xFFFF.
- Stage 2 (write register): holds the packed row and its address.
- Write rule: bram_we = (s2_valid && mem_grant) ? lane_mask : 0.
  - bram_addr and bram_wdata are driven from stage 2 whenever s2_valid.
  - The write is committed in the cycle where bram_we != 0, or where s2_valid && mem_grant with mask=0 (counts as written, no enables).
  - On commit: written increments and next_addr advances by stride.
- Address arithmetic is modulo 2^AWIDTH; wrap past 1023 is silent.
- Stall rules:
  - s2 advances when !s2_valid || commit.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = (state==RUN) && (accepted < num_rows) && (!s1_valid || s2 advances).
  - With mem_grant low, the pipeline holds and data and address stay stable.
- Latency: accepted row to bram_we = 2 cycles when mem_grant stays high. Throughput is 1 row/cycle.
- Rows beyond num_rows are never accepted (in_ready=0).
- Reset mid-job: returns to IDLE in the same edge and drops both stages. No write or done is produced on or after the reset edge.

Test Plan:
- Single row, every lane = 4352 (68.0 in Q.6), full mask, grant high -> one write at base 0x20, all bytes 0x7F, sat_count=16, done 3 cycles after accept.
- Lanes {96, -4, -5, 8188, -8192} (others 0), num_rows=1 -> bytes 0x0C, 0x00, 0xFF, 0x7F, 0x80; sat_count=2.
- num_rows=4, base=0x3FE, stride=1, back-to-back valid -> writes at 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; 5th offered row never accepted.
- mem_grant low for 5 cycles mid-job -> bram_we=0 and in_ready falls within 2 cycles; addr/data hold; rows resume in order with no loss or duplication.
- mask=0x00FF, stride=2, base=0x20, 2 rows -> bram_we=0x00FF at 0x20, then 0x22.
- Edge cases:
  - num_rows=0 -> done pulse, no writes.
  - reset asserted one cycle after the first accept -> no write, busy=0 next cycle.
  - start during RUN -> ignored.
